frv_core_fetch_req: RTL and testbench
=====================================

FRV_CORE_FETCH_REQ -- requirements
Module: frv_core_fetch_req

Interface
REQ-001 SHALL have parameter FRV_PC_RESET_VALUE, default 32'h8000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter RSP_DEPTH, default 2, meaning the response FIFO depth and the maximum number of outstanding requests.
REQ-003 SHALL have ports, clock and reset first:
- g_clk  in  1  global clock
- g_reset  in  1  synchronous, active-high reset
- cf_req  in  1  control-flow redirect request
- cf_target  in  32  redirect target, halfword aligned
- cf_ack  out  1  redirect accepted
- f_flush  out  1  flush pulse to the fetch buffer
- imem_req  out  1  memory request valid
- imem_addr  out  32  word-aligned fetch address
- imem_gnt  in  1  request accepted
- imem_recv  in  1  response valid
- imem_ack  out  1  response accepted
- imem_error  in  1  response error
- imem_rdata  in  32  response data
- f_4byte  out  1  push a 4-byte word to the buffer
- f_2byte  out  1  push the upper halfword only
- f_err  out  1  error flag for the pushed data
- f_in  out  32  pushed data
- f_ready  in  1  the buffer accepts a push this cycle

Function
REQ-004 SHALL hold fetch address fpc, word aligned; imem_addr = fpc.
REQ-005 SHALL advance fpc by 4 on each cycle with imem_req && imem_gnt; wrap-around modulo 2^32.
REQ-006 SHALL assert imem_req only when all of the following hold: not halted; outstanding + fifo_count < RSP_DEPTH; no redirect accepted this cycle.
REQ-007 Once imem_req is asserted, it and imem_addr SHALL stay stable until imem_gnt.
REQ-008 outstanding SHALL increment on imem_req && imem_gnt and decrement on imem_recv && imem_ack; it counts stale requests and never exceeds RSP_DEPTH.
REQ-009 SHALL drive imem_ack = 1 whenever the FIFO is not full; by the credit rule, a live response always finds space.
REQ-010 SHALL push each accepted, non-stale response into the FIFO as {err, half, data}.
REQ-011 The FIFO head SHALL drive f_in = data, f_err = err, f_4byte = valid && !half && f_ready, f_2byte = valid && half && f_ready; it pops on f_4byte || f_2byte.
REQ-012 The FIFO SHALL support a simultaneous push and pop when full-minus-one or empty, with a registered output and no bypass; latency from imem_recv to f_* is 1 cycle minimum.
REQ-013 SHALL drive cf_ack = cf_req && !(imem_req && !imem_gnt); f_flush SHALL equal cf_req && cf_ack.
REQ-014 On an accepted redirect:
- fpc <= {cf_target[31:2], 2'b00}
- misalign <= cf_target[1]
- FIFO cleared
- halted cleared
- stale <= outstanding + (imem_req && imem_gnt) - (imem_recv && imem_ack)
REQ-015 A response accepted while stale != 0 SHALL be dropped and SHALL decrement stale; a response arriving in the redirect cycle itself is dropped.
REQ-016 The first non-stale response after a redirect SHALL carry half = misalign; misalign then clears.
REQ-017 A response with imem_error SHALL set halted, which blocks new requests until the next accepted redirect; already-outstanding responses are still delivered.
REQ-018 If a redirect and reset are asserted in the same cycle, reset SHALL win.

Reset
REQ-019 On g_reset at a clock edge:
- fpc = FRV_PC_RESET_VALUE
- outstanding = 0, stale = 0
- FIFO empty
- misalign = 0, halted = 0
- imem_req rises on the first cycle after reset is released
REQ-020 Outputs in reset: f_4byte, f_2byte, f_err, cf_ack, f_flush = 0; f_in = 0; imem_ack = 1.

Structure
REQ-021 FRV_PC_RESET_VALUE and the FIFO entry layout SHALL live in the shared core header.
REQ-022 The response FIFO SHALL be a sub-module, frv_core_fetch_rsp_fifo.

Verification
REQ-023 Release reset, imem_gnt = 1, imem_recv one cycle after each grant, f_ready = 1 -> imem_addr 0x80000000, then 0x80000004, and so on; f_4byte pulses with matching rdata.
REQ-024 Redirect to 0x00000102 -> imem_addr 0x00000100; first push is f_2byte with f_in = rdata; next push is f_4byte from 0x00000104.
REQ-025 Redirect with 2 requests outstanding -> both responses dropped, no f_* pulse, next imem_addr = target.
REQ-026 f_ready = 0 -> FIFO fills with 2 entries, imem_req deasserts, no data lost; f_ready = 1 -> entries drained in order.
REQ-027 imem_error on response at 0x80000008 -> f_4byte with f_err = 1, imem_req stays low until cf_req to 0x200, then fetch resumes at 0x200.
REQ-028 cf_req while imem_req is high and imem_gnt is low -> cf_ack = 0 until the grant; that granted request is dropped as stale.

Source files
------------

// File: rtl/frv_core_fetch_req_pkg.sv
// rtl/frv_core_fetch_req_pkg.sv - shared fetch constants and response FIFO entry layout
package frv_core_fetch_req_pkg;

  localparam logic [31:0] FRV_PC_RESET_VALUE = 32'h8000_0000;

  // half marks an entry whose lower halfword precedes the redirect target
  typedef struct packed {
    logic        err;
    logic        half;
    logic [31:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/frv_core_fetch_rsp_fifo.sv
// rtl/frv_core_fetch_rsp_fifo.sv - response FIFO with registered head and synchronous clear
module frv_core_fetch_rsp_fifo
  import frv_core_fetch_req_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         push_tvalid,
  input  fetch_entry_t                 push_tdata,
  output logic                         push_tready,
  output logic                         pop_tvalid,
  output fetch_entry_t                 pop_tdata,
  input  logic                         pop_tready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign push_tready = (count != FULL);
  assign pop_tvalid  = (count != '0);
  assign pop_tdata   = mem[rd_ptr];
  assign do_push     = push_tvalid && push_tready;
  assign do_pop      = pop_tvalid && pop_tready;

  // Head is read straight from storage, so a push is visible one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_tdata;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_next(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/frv_core_fetch_req.sv
// rtl/frv_core_fetch_req.sv - instruction fetch request generator with credit-limited response FIFO
module frv_core_fetch_req #(
  parameter logic [31:0] FRV_PC_RESET_VALUE = frv_core_fetch_req_pkg::FRV_PC_RESET_VALUE,
  parameter int          RSP_DEPTH          = 2
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        cf_req,
  input  logic [31:0] cf_target,
  output logic        cf_ack,
  output logic        f_flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_recv,
  output logic        imem_ack,
  input  logic        imem_error,
  input  logic [31:0] imem_rdata,
  output logic        f_4byte,
  output logic        f_2byte,
  output logic        f_err,
  output logic [31:0] f_in,
  input  logic        f_ready
);

  import frv_core_fetch_req_pkg::*;

  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic [31:0]   fpc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] stale;
  logic [CW-1:0] fifo_count;
  logic          misalign;
  logic          halted;
  logic          pend;
  logic          credit_ok;
  logic          fire;
  logic          rsp_fire;
  logic          redirect;
  logic          rsp_live;
  logic          push_ready;
  logic          head_valid;
  logic          pop_ready;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;
  logic          unused_target_bit;

  assign unused_target_bit = cf_target[0];

  // Stale requests still hold a credit, so a live response always finds FIFO space.
  assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < (CW+1)'(RSP_DEPTH);

  // A raised request is held until granted; a redirect only competes with new requests.
  assign imem_req  = !g_reset && (pend || (!cf_req && !halted && credit_ok));
  assign imem_addr = fpc;
  assign cf_ack    = !g_reset && cf_req && !(imem_req && !imem_gnt);
  assign f_flush   = cf_req && cf_ack;
  assign redirect  = cf_ack;
  assign imem_ack  = g_reset || push_ready;

  assign fire            = imem_req && imem_gnt;
  assign rsp_fire        = imem_recv && imem_ack;
  assign rsp_live        = rsp_fire && !redirect && (stale == '0);
  assign outstanding_nxt = outstanding + CW'(fire) - CW'(rsp_fire);
  assign push_entry      = '{err: imem_error, half: misalign, data: imem_rdata};

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      fpc         <= FRV_PC_RESET_VALUE;
      outstanding <= '0;
      stale       <= '0;
      misalign    <= 1'b0;
      halted      <= 1'b0;
      pend        <= 1'b0;
    end else begin
      outstanding <= outstanding_nxt;
      pend        <= imem_req && !imem_gnt;
      if (redirect) begin
        fpc      <= {cf_target[31:2], 2'b00};
        misalign <= cf_target[1];
        halted   <= 1'b0;
        stale    <= outstanding_nxt;
      end else begin
        if (fire) fpc <= fpc + 32'd4;
        if (rsp_fire && (stale != '0)) stale <= stale - CW'(1);
        if (rsp_live) begin
          misalign <= 1'b0;
          if (imem_error) halted <= 1'b1;
        end
      end
    end
  end

  frv_core_fetch_rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk         (g_clk),
    .reset       (g_reset),
    .clear       (redirect),
    .push_tvalid (rsp_live),
    .push_tdata  (push_entry),
    .push_tready (push_ready),
    .pop_tvalid  (head_valid),
    .pop_tdata   (head),
    .pop_tready  (pop_ready),
    .count       (fifo_count)
  );

  assign pop_ready = f_ready && !g_reset;
  assign f_4byte   = head_valid && !head.half && pop_ready;
  assign f_2byte   = head_valid && head.half && pop_ready;
  assign f_err     = !g_reset && head_valid && head.err;
  assign f_in      = g_reset ? '0 : head.data;

endmodule

// File: tb/tb_frv_core_fetch_req.sv
// tb/tb_frv_core_fetch_req.sv - self-checking bench for frv_core_fetch_req
module tb_frv_core_fetch_req;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        g_clk = 1'b0;
  logic        g_reset, cf_req, cf_ack, f_flush, imem_req, imem_gnt, imem_recv, imem_ack;
  logic        imem_error, f_4byte, f_2byte, f_err, f_ready;
  logic [31:0] cf_target, imem_addr, imem_rdata, f_in;

  always #5 g_clk = ~g_clk;

  frv_core_fetch_req #(.FRV_PC_RESET_VALUE(RST_PC), .RSP_DEPTH(DEPTH)) dut (
    .g_clk(g_clk), .g_reset(g_reset), .cf_req(cf_req), .cf_target(cf_target),
    .cf_ack(cf_ack), .f_flush(f_flush), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_recv(imem_recv), .imem_ack(imem_ack),
    .imem_error(imem_error), .imem_rdata(imem_rdata), .f_4byte(f_4byte),
    .f_2byte(f_2byte), .f_err(f_err), .f_in(f_in), .f_ready(f_ready)
  );

  typedef struct { logic [31:0] addr; int ep; } req_t;
  typedef struct { logic [31:0] data; logic half; logic err; } ent_t;

  req_t        req_q[$];     // granted requests awaiting a response, tagged with redirect epoch
  ent_t        exp_q[$];     // expected buffer contents
  ent_t        act_push[$];
  logic [31:0] act_grant[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  logic [31:0] m_pc;
  int          epoch = 0;
  logic        m_first, m_mis, m_halted, m_pend;

  logic        rst_en = 1'b1, gnt_en = 1'b1, rdy_en = 1'b1, cf_en = 1'b0, rsp_hold = 1'b0;
  logic [31:0] cf_tgt = '0, err_addr = 32'hFFFF_FFFF;
  logic        last_req, last_iack, last_cfack, e_cf_last;
  int          g0, p0, k;
  ent_t        e;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a + 32'h1000_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] grant_at(input int idx);
    return (idx < act_grant.size()) ? act_grant[idx] : 32'hDEAD_DEAD;
  endfunction

  function automatic ent_t push_at(input int idx);
    ent_t r = '{32'hDEAD_DEAD, 1'b1, 1'b1};
    if (idx < act_push.size()) r = act_push[idx];
    return r;
  endfunction

  // One clock: drive at negedge, compare against the model, advance the model for the edge.
  task automatic step();
    logic e_req, e_cf, e_iack, e_pop;
    ent_t hd;
    req_t r;
    @(negedge g_clk);
    g_reset = rst_en; imem_gnt = gnt_en; f_ready = rdy_en; cf_req = cf_en; cf_target = cf_tgt;
    if (!rst_en && req_q.size() > 0 && !rsp_hold) begin
      imem_recv  = 1'b1;
      imem_rdata = mem_data(req_q[0].addr);
      imem_error = (req_q[0].addr == err_addr);
    end else begin
      imem_recv  = 1'b0;
      imem_rdata = $urandom;
      imem_error = 1'($urandom_range(0, 1));
    end
    #1;
    last_req = imem_req; last_iack = imem_ack; last_cfack = cf_ack;
    if (rst_en) begin
      chk("rst_imem_req", imem_req, 0);  chk("rst_cf_ack", cf_ack, 0);
      chk("rst_f_flush", f_flush, 0);    chk("rst_f_4byte", f_4byte, 0);
      chk("rst_f_2byte", f_2byte, 0);    chk("rst_f_err", f_err, 0);
      chk("rst_f_in", f_in, 0);          chk("rst_imem_ack", imem_ack, 1);
      req_q.delete(); exp_q.delete();
      m_pc = RST_PC; m_first = 1'b0; m_mis = 1'b0; m_halted = 1'b0; m_pend = 1'b0;
      e_cf_last = 1'b0;
    end else begin
      e_req  = m_pend || (!cf_req && !m_halted && (req_q.size() + exp_q.size() < DEPTH));
      e_cf   = cf_req && !(e_req && !imem_gnt);
      e_iack = exp_q.size() < DEPTH;
      e_pop  = exp_q.size() > 0 && f_ready;
      hd     = (exp_q.size() > 0) ? exp_q[0] : '{32'h0, 1'b0, 1'b0};
      chk("imem_req", imem_req, e_req);
      if (e_req) chk("imem_addr", imem_addr, m_pc);
      chk("cf_ack", cf_ack, e_cf);
      chk("f_flush", f_flush, e_cf);
      chk("imem_ack", imem_ack, e_iack);
      chk("f_4byte", f_4byte, e_pop && !hd.half);
      chk("f_2byte", f_2byte, e_pop && hd.half);
      if (e_pop) begin
        chk("f_in", f_in, hd.data);
        chk("f_err", f_err, hd.err);
      end
      if (imem_req && imem_gnt) act_grant.push_back(imem_addr);
      if (f_4byte || f_2byte) act_push.push_back('{f_in, f_2byte, f_err});

      if (e_pop) void'(exp_q.pop_front());
      if (imem_recv && e_iack) begin
        r = req_q.pop_front();
        if (!e_cf && r.ep == epoch) begin
          exp_q.push_back('{mem_data(r.addr), m_first ? m_mis : 1'b0, imem_error});
          m_first = 1'b0;
          if (imem_error) m_halted = 1'b1;
        end
      end
      if (e_req && imem_gnt) begin
        req_q.push_back('{m_pc, epoch});
        m_pc = m_pc + 32'd4;
      end
      if (e_cf) begin
        epoch++;
        m_pc = {cf_target[31:2], 2'b00}; m_mis = cf_target[1]; m_first = 1'b1;
        m_halted = 1'b0; exp_q.delete();
      end
      m_pend    = e_req && !imem_gnt;
      e_cf_last = e_cf;
    end
    @(posedge g_clk);
  endtask

  task automatic redirect(input logic [31:0] tgt);
    cf_en = 1'b1; cf_tgt = tgt;
    for (int i = 0; i < 10; i++) begin
      step();
      if (e_cf_last) break;
    end
    if (!e_cf_last) begin
      n_checks++; n_fail++;
      $display("FAIL redirect_timeout: got no ack expected ack for 0x%0h", tgt);
    end
    cf_en = 1'b0;
  endtask

  initial begin
    g_reset = 1'b1; cf_req = 1'b0; cf_target = '0; imem_gnt = 1'b0; imem_recv = 1'b0;
    imem_error = 1'b0; imem_rdata = '0; f_ready = 1'b0;

    // Reset, then streaming fetch from the reset vector
    rst_en = 1'b1; repeat (3) step(); rst_en = 1'b0;
    repeat (8) step();
    chk("s1_grant0", grant_at(0), 32'h8000_0000);
    chk("s1_grant1", grant_at(1), 32'h8000_0004);
    chk("s1_grant2", grant_at(2), 32'h8000_0008);
    e = push_at(0);
    chk("s1_push0_data", e.data, 32'h9000_0000);
    chk("s1_push0_half", e.half, 0);

    // Buffer stall: FIFO fills, requests stop, then drains in order
    p0 = act_push.size(); rdy_en = 1'b0;
    repeat (6) step();
    chk("s2_no_push", act_push.size() - p0, 0);
    chk("s2_req_low", last_req, 0);
    chk("s2_ack_low", last_iack, 0);
    rdy_en = 1'b1;
    repeat (4) step();
    chk("s2_drained", (act_push.size() - p0) >= 2, 1);

    // Misaligned redirect: first push is the upper halfword
    redirect(32'h0000_0102);
    g0 = act_grant.size(); p0 = act_push.size();
    repeat (8) step();
    chk("s3_grant0", grant_at(g0), 32'h0000_0100);
    chk("s3_grant1", grant_at(g0 + 1), 32'h0000_0104);
    e = push_at(p0);
    chk("s3_push0_data", e.data, 32'h1000_0100);
    chk("s3_push0_half", e.half, 1);
    e = push_at(p0 + 1);
    chk("s3_push1_data", e.data, 32'h1000_0104);
    chk("s3_push1_half", e.half, 0);

    // Redirect with two requests outstanding: both responses dropped
    rsp_hold = 1'b1;
    for (int i = 0; i < 10 && req_q.size() < 2; i++) step();
    chk("s4_two_outstanding", req_q.size(), 2);
    redirect(32'h0000_0300);
    g0 = act_grant.size(); p0 = act_push.size(); rsp_hold = 1'b0;
    repeat (8) step();
    chk("s4_grant0", grant_at(g0), 32'h0000_0300);
    e = push_at(p0);
    chk("s4_push0_data", e.data, 32'h1000_0300);

    // Reset wins over a simultaneous redirect; then an error response halts fetch
    rst_en = 1'b1; cf_en = 1'b1; cf_tgt = 32'h0000_0500;
    repeat (2) step();
    chk("s5_rst_cf_ack", last_cfack, 0);
    rst_en = 1'b0; cf_en = 1'b0; err_addr = 32'h8000_0008;
    g0 = act_grant.size(); p0 = act_push.size();
    repeat (12) step();
    chk("s5_grant0", grant_at(g0), 32'h8000_0000);
    k = -1;
    for (int i = p0; i < act_push.size(); i++) if (act_push[i].err && k < 0) k = i;
    e = push_at(k < 0 ? act_push.size() : k);
    chk("s5_err_data", e.data, 32'h9000_0008);
    chk("s5_err_4byte", e.half, 0);
    chk("s5_halted_req", last_req, 0);
    redirect(32'h0000_0200);
    g0 = act_grant.size();
    repeat (6) step();
    chk("s5_resume", grant_at(g0), 32'h0000_0200);

    // Redirect against a pending ungranted request
    gnt_en = 1'b0; err_addr = 32'hFFFF_FFFF;
    repeat (4) step();
    chk("s6_req_pending", last_req, 1);
    cf_en = 1'b1; cf_tgt = 32'h0000_0400;
    step();
    chk("s6_cf_blocked", last_cfack, 0);
    gnt_en = 1'b1;
    step();
    chk("s6_cf_acked", last_cfack, 1);
    cf_en = 1'b0;
    g0 = act_grant.size(); p0 = act_push.size();
    repeat (8) step();
    chk("s6_grant0", grant_at(g0), 32'h0000_0400);
    e = push_at(p0);
    chk("s6_push0_data", e.data, 32'h1000_0400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
